// File: rtl/game_state_ctrl.sv
// Game sequencer: button debounce, frame tick, IDLE/RUN/DYING/OVER control.
// Drives the score counter pulses and the dino/obstacle freeze.
module game_state_ctrl #(
    parameter int DB_CYCLES    = 1000,
    parameter int DB_W         = 10,
    parameter int DEATH_FRAMES = 30,
    parameter int HOLDOFF      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       frame_end,
    input  logic       collision,
    output logic       game_tick,
    output logic       game_start,
    output logic       game_over,
    output logic       score_clr,
    output logic       jump_pulse,
    output logic       frozen,
    output logic [1:0] state
);

    localparam int FMAX =
        (DEATH_FRAMES > HOLDOFF) ? DEATH_FRAMES : HOLDOFF;
    localparam int FW = $clog2(FMAX + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [FW-1:0]   DF_LAST = FW'(DEATH_FRAMES - 1);
    localparam logic [FW-1:0]   HO_MAX  = FW'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t          st_q;
    state_t          st_n;
    logic [FW-1:0]   fcnt_q;
    logic [FW-1:0]   fcnt_n;
    logic            btn_m;
    logic            btn_s;
    logic            db_lvl;
    logic            db_lvl_q;
    logic [DB_W-1:0] db_cnt;
    logic            fe_q;
    logic            rst_q;
    logic            press;
    logic            tick_c;
    logic            start_n;
    logic            over_n;
    logic            jump_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_m    <= btn_raw;
            btn_s    <= btn_m;
            db_lvl_q <= db_lvl;
            if (btn_s == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_lvl <= ~db_lvl;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // fe_q follows frame_end through reset so a level that is
    // already high when reset drops is not mistaken for an edge
    always_ff @(posedge clk) begin
        fe_q <= frame_end;
    end

    assign press  = db_lvl & ~db_lvl_q;
    assign tick_c = frame_end & ~fe_q;

    always_comb begin
        st_n    = st_q;
        fcnt_n  = fcnt_q;
        start_n = 1'b0;
        over_n  = 1'b0;
        jump_n  = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (press) begin
                    st_n    = RUN;
                    start_n = 1'b1;
                end
            end
            RUN: begin
                if (tick_c && collision) begin
                    st_n   = DYING;
                    over_n = 1'b1;
                end else if (press) begin
                    jump_n = 1'b1;
                end
            end
            DYING: begin
                if (tick_c) begin
                    if (fcnt_q == DF_LAST) begin
                        st_n = OVER;
                    end else begin
                        fcnt_n = fcnt_q + FW'(1);
                    end
                end
            end
            OVER: begin
                if (tick_c && fcnt_q != HO_MAX) begin
                    fcnt_n = fcnt_q + FW'(1);
                end
                if (press && fcnt_q == HO_MAX) begin
                    st_n    = RUN;
                    start_n = 1'b1;
                end
            end
            default: st_n = IDLE;
        endcase
        if (st_n != st_q) begin
            fcnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= IDLE;
            fcnt_q     <= '0;
            rst_q      <= 1'b1;
            game_tick  <= 1'b0;
            game_start <= 1'b0;
            game_over  <= 1'b0;
            score_clr  <= 1'b0;
            jump_pulse <= 1'b0;
            frozen     <= 1'b0;
        end else begin
            st_q       <= st_n;
            fcnt_q     <= fcnt_n;
            rst_q      <= 1'b0;
            // rst_q keeps the first post-reset cycle pulse-free
            game_tick  <= tick_c & ~rst_q;
            game_start <= start_n;
            game_over  <= over_n;
            score_clr  <= start_n;
            jump_pulse <= jump_n;
            frozen     <= (st_n == DYING) || (st_n == OVER);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: phase table plus
// hand-timed sequences for collision, holdoff and reset.
module tb_game_state_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       frame_end;
    logic       collision;
    logic       game_tick;
    logic       game_start;
    logic       game_over;
    logic       score_clr;
    logic       jump_pulse;
    logic       frozen;
    logic [1:0] state;

    game_state_ctrl #(
        .DB_CYCLES   (4),
        .DB_W        (3),
        .DEATH_FRAMES(3),
        .HOLDOFF     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .frame_end (frame_end),
        .collision (collision),
        .game_tick (game_tick),
        .game_start(game_start),
        .game_over (game_over),
        .score_clr (score_clr),
        .jump_pulse(jump_pulse),
        .frozen    (frozen),
        .state     (state)
    );

    typedef struct {
        int         cycles;
        logic       btn;
        logic       col;
        int         d_start;
        int         d_over;
        int         d_jump;
        int         lat;
        logic [1:0] st;
        logic       frz;
    } vec_t;

    vec_t vt[7];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_tick = 0;
    int n_start = 0;
    int n_over = 0;
    int n_jump = 0;
    int n_clr  = 0;
    int n_bad  = 0;
    int fcyc   = 0;

    int   k;
    int   s0;
    int   o0;
    int   j0;
    int   first;
    int   t_at;
    int   o_at;
    int   found;
    int   snap;
    logic prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // frame_end: 8 clk high out of every 40
    initial begin
        frame_end = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            fcyc++;
            frame_end = ((fcyc % 40) >= 32);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (game_tick === 1'b1) n_tick++;
            if (game_start === 1'b1) n_start++;
            if (game_over === 1'b1) n_over++;
            if (jump_pulse === 1'b1) n_jump++;
            if (score_clr === 1'b1) n_clr++;
            if (game_start === 1'b1 && game_over === 1'b1) n_bad++;
            if (score_clr !== game_start) n_bad++;
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return game_tick;
            1:       return game_start;
            2:       return game_over;
            3:       return jump_pulse;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_pulse(input int sel, input int maxc,
                              output int kk);
        kk = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (sel_sig(sel) === 1'b1) begin
                kk = i;
                break;
            end
        end
    endtask

    initial begin
        vt[0] = '{100, 1'b0, 1'b0, 0, 0, 0, 0, 2'd0, 1'b0};
        vt[1] = '{20,  1'b1, 1'b0, 1, 0, 0, 7, 2'd1, 1'b0};
        vt[2] = '{20,  1'b0, 1'b0, 0, 0, 0, 0, 2'd1, 1'b0};
        vt[3] = '{2,   1'b1, 1'b0, 0, 0, 0, 0, 2'd1, 1'b0};
        vt[4] = '{20,  1'b0, 1'b0, 0, 0, 0, 0, 2'd1, 1'b0};
        vt[5] = '{20,  1'b1, 1'b0, 0, 0, 1, 7, 2'd1, 1'b0};
        vt[6] = '{20,  1'b0, 1'b0, 0, 0, 0, 0, 2'd1, 1'b0};

        rst       = 1'b1;
        btn_raw   = 1'b0;
        collision = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_frozen", 32'(frozen), 0);
        check("rst_pulses", 32'({game_tick, game_start,
              game_over, score_clr, jump_pulse}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pulses", 32'({game_tick, game_start,
              game_over, score_clr, jump_pulse}), 0);

        wait_pulse(0, 60, k);
        check("tick_seen", 32'(k != 0), 1);
        wait_pulse(0, 60, k);
        check("tick_period", k, 40);

        for (int i = 0; i < 7; i++) begin
            btn_raw   = vt[i].btn;
            collision = vt[i].col;
            s0    = n_start;
            o0    = n_over;
            j0    = n_jump;
            first = 0;
            for (int c = 1; c <= vt[i].cycles; c++) begin
                @(negedge clk);
                if (first == 0 && (game_start || jump_pulse))
                    first = c;
            end
            check($sformatf("v%0d_start", i), n_start - s0,
                  vt[i].d_start);
            check($sformatf("v%0d_over", i), n_over - o0,
                  vt[i].d_over);
            check($sformatf("v%0d_jump", i), n_jump - j0,
                  vt[i].d_jump);
            check($sformatf("v%0d_lat", i), first, vt[i].lat);
            check($sformatf("v%0d_state", i), 32'(state),
                  32'(vt[i].st));
            check($sformatf("v%0d_frozen", i), 32'(frozen),
                  32'(vt[i].frz));
        end

        // press lands on the same cycle as a collision tick
        prev  = frame_end;
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (frame_end && !prev) begin
                found = 1;
                break;
            end
            prev = frame_end;
        end
        check("fe_rise_seen", found, 1);
        repeat (34) @(negedge clk);
        btn_raw   = 1'b1;
        collision = 1'b1;
        j0   = n_jump;
        o0   = n_over;
        t_at = 0;
        o_at = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (t_at == 0 && game_tick) t_at = c;
            if (o_at == 0 && game_over) o_at = c;
        end
        check("col_tick_at", t_at, 7);
        check("col_over_at", o_at, 7);
        check("col_over_cnt", n_over - o0, 1);
        check("col_no_jump", n_jump - j0, 0);
        check("col_state", 32'(state), 2);
        check("col_frozen", 32'(frozen), 1);
        collision = 1'b0;
        btn_raw   = 1'b0;

        for (int n = 1; n <= 3; n++) begin
            wait_pulse(0, 60, k);
            check($sformatf("dying_tick%0d", n), 32'(k != 0), 1);
            check($sformatf("dying_state%0d", n), 32'(state),
                  (n == 3) ? 3 : 2);
        end
        check("over_frozen", 32'(frozen), 1);

        // press during holdoff, held through its expiry
        btn_raw = 1'b1;
        s0 = n_start;
        wait_pulse(0, 60, k);
        check("hold_tick1", 32'(k != 0), 1);
        check("hold_state1", 32'(state), 3);
        wait_pulse(0, 60, k);
        check("hold_tick2", 32'(k != 0), 1);
        repeat (5) @(negedge clk);
        check("hold_state2", 32'(state), 3);
        check("hold_no_start", n_start - s0, 0);
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_state3", 32'(state), 3);
        btn_raw = 1'b1;
        wait_pulse(1, 20, k);
        check("restart_lat", k, 7);
        check("restart_state", 32'(state), 1);
        check("restart_frozen", 32'(frozen), 0);
        check("restart_clr", 32'(score_clr), 1);
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);

        btn_raw = 1'b1;
        wait_pulse(3, 20, k);
        check("jump_lat", k, 7);
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);

        // reset while dying
        collision = 1'b1;
        wait_pulse(2, 60, k);
        check("d_over_seen", 32'(k != 0), 1);
        check("d_state", 32'(state), 2);
        rst       = 1'b1;
        collision = 1'b0;
        snap = n_tick + n_start + n_over + n_jump + n_clr;
        @(negedge clk);
        check("d_rst_state", 32'(state), 0);
        check("d_rst_frozen", 32'(frozen), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("d_rst_pulses",
              n_tick + n_start + n_over + n_jump + n_clr - snap, 0);
        check("d_rst_state2", 32'(state), 0);

        check("invariants", n_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
